// File: rtl/sik_mem_arbiter_pkg.sv
// Shared definitions for the two-thread data-memory arbiter.
// State encodings, thread IDs and word/address widths.
package sik_mem_arbiter_pkg;

  localparam int WORD_W  = 16;
  localparam int ADDR_W  = 16;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  localparam logic T0 = 1'b0;
  localparam logic T1 = 1'b1;

endpackage

// File: rtl/sik_mem_arbiter.sv
// Round-robin arbiter sharing one synchronous data-memory port
// between two threads: IDLE -> ISSUE -> RESP, one access per 3 cycles.
module sik_mem_arbiter
  import sik_mem_arbiter_pkg::*;
#(
  parameter int AW = ADDR_W,
  parameter int DW = WORD_W
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          halt,
  input  logic          req0,
  input  logic          req1,
  input  logic          we0,
  input  logic          we1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] wdata0,
  input  logic [DW-1:0] wdata1,
  output logic          ack0,
  output logic          ack1,
  output logic [DW-1:0] rdata0,
  output logic [DW-1:0] rdata1,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy
);

  state_t state, state_nx;
  logic   rr;
  logic   owner;
  logic   lat_we;
  logic   grant;
  logic   win;
  logic   win_we;

  // Lone requester wins; on contention the pointer decides.
  function automatic logic rr_pick(
    input logic r0,
    input logic r1,
    input logic p
  );
    if (r0 && r1) return p;
    return r1 ? T1 : T0;
  endfunction

  always_comb begin
    grant  = (state == IDLE) && !halt && (req0 || req1);
    win    = rr_pick(req0, req1, rr);
    win_we = win ? we1 : we0;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = ISSUE;
      ISSUE:   state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Port controls are registered so ISSUE drives them glitch-free.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      rr        <= T0;
      owner     <= T0;
      lat_we    <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      state  <= state_nx;
      mem_en <= grant;
      mem_we <= grant && win_we;
      if (grant) begin
        owner     <= win;
        lat_we    <= win_we;
        mem_addr  <= win ? addr1 : addr0;
        mem_wdata <= win ? wdata1 : wdata0;
      end
      if (state == RESP) rr <= ~owner;
    end
  end

  always_comb begin
    ack0   = (state == RESP) && (owner == T0);
    ack1   = (state == RESP) && (owner == T1);
    rdata0 = (ack0 && !lat_we) ? mem_rdata : '0;
    rdata1 = (ack1 && !lat_we) ? mem_rdata : '0;
    busy   = (state != IDLE);
  end

endmodule

// File: doc/sik_mem_arbiter.md
# sik_mem_arbiter

Two-thread arbiter for the single shared data-memory port of the two-thread stack processor. Thread 0 and thread 1 each issue `load`/`store` requests; the arbiter grants one at a time in round-robin order, drives the memory port, and returns an acknowledge with read data. It sits between the two memory-stage pipelines and the 65536-word `WORD` memory.

## Interface
Parameters:
- `AW`, 16: address width (65536 words).
- `DW`, 16: data width (one `WORD`).

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `halt`  in  1: when high, no new grants; an access already in flight completes.
- `req0`, `req1`  in  1: thread request. Held high with its fields stable until the cycle its ack is high.
- `we0`, `we1`  in  1: 1 = `store`, 0 = `load`.
- `addr0`, `addr1`  in  `AW`: word address.
- `wdata0`, `wdata1`  in  `DW`: store data.
- `ack0`, `ack1`  out  1: one-cycle completion pulse.
- `rdata0`, `rdata1`  out  `DW`: load data, valid when ack is high; 0 otherwise.
- `mem_en`  out  1: memory port enable.
- `mem_we`  out  1: memory write enable.
- `mem_addr`  out  `AW`: memory address.
- `mem_wdata`  out  `DW`: memory write data.
- `mem_rdata`  in  `DW`: memory read data, one-cycle synchronous read latency.
- `busy`  out  1: high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, RESP. Encodings are held in 2-bit `STATE` registers.
- IDLE:
  - If `halt`=0 and any `req` is high, choose a winner.
  - A lone requester always wins. If both requests are high, the winner is the round-robin pointer `rr`.
  - Latch `owner`, `we`, `addr` and `wdata` into registers, then go to ISSUE.
  - Otherwise stay in IDLE.
- ISSUE:
  - Registered `mem_en`=1, with `mem_we`/`mem_addr`/`mem_wdata` taken from the latched fields.
  - Go to RESP unconditionally.
- RESP:
  - `ack[owner]`=1, decoded from state and owner.
  - For a load, `rdata[owner]`=`mem_rdata`; for a store, `rdata[owner]`=0.
  - Set `rr` to the non-owner thread, then go to IDLE.
  - Requests are not sampled in RESP, because a requester's `req` is still high in its ack cycle.
- Outside ISSUE, `mem_en`=0 and `mem_we`=0; `mem_addr`/`mem_wdata` hold their last value.
- `halt` is sampled only in IDLE. Raising it during ISSUE or RESP does not abort the access.
- No address or data arithmetic is done here; fields pass through unmodified, at full width.

## Timing
- Reset (asynchronous): state IDLE, `rr`=0, `owner`=0.
  - Outputs `ack0`/`ack1`/`mem_en`/`mem_we`/`busy` are 0.
  - `mem_addr`/`mem_wdata`/`rdata0`/`rdata1` are 0.
- Reset mid-operation: the access is dropped with no ack, and any write not yet issued is lost. Requesters reissue after reset.
- Latency, with the request sampled at the edge ending cycle 0:
  - `mem_en` high in cycle 1.
  - ack high in cycle 2.
  - Earliest next grant is sampled at the end of cycle 3.
- Throughput: one access per 3 cycles.
- Requester rules:
  - Drop `req` or present a new request starting the cycle after ack.
  - A request that is held continuously is not re-served twice without an intervening ack.
- Simultaneous requests: winner is `rr`. After a served access, `rr` flips away from the owner, so with both requests held continuously the grants alternate 0,1,0,1.
- Starvation bound: a held request is granted within 6 cycles of the previous grant.

## Structure
- Shared include `sik_defs`:
  - `WORD`, address width, memory size.
  - `STATE` width and the IDLE/ISSUE/RESP encodings.
  - Thread IDs `T0`=0, `T1`=1.
- Single module. The winner select is a local function `rr_pick(req0, req1, rr)` and does not need a sub-module.

## Test plan
- Reset, then a lone `req0` load from `addr0`=16'h0040 with memory holding 16'h1234 → `mem_en` high in cycle 1 with `mem_addr`=16'h0040; `ack0` in cycle 2 with `rdata0`=16'h1234; `ack1`=0 throughout.
- `req1` store, `addr1`=16'hFFFF, `wdata1`=16'hBEEF, then a `req1` load of the same address → write issued with `mem_we`=1; the load returns 16'hBEEF.
- `req0` and `req1` held high together from reset for 12 cycles → acks in the order 0,1,0,1, each 3 cycles apart.
- `halt`=1 while `req0` is high → `mem_en` stays 0 and `busy`=0. Then `halt` is raised during ISSUE of a `req1` access → `ack1` still pulses and there is no further grant.
- `reset` pulsed during ISSUE of a thread-0 store → all outputs are 0 immediately, no `ack0`, and `rr`=0. A following simultaneous request grants thread 0 first.
- Store acknowledge → `rdata0`=0 during `ack0`, and `rdata1` stays 0 on the non-owner port.
